stopwatch_ctrl: RTL

Control FSM for the stopwatch digit chain. Decodes start/stop, lap and clear buttons and generates the prescaled tick enable that drives the least-significant decade counter. Issues the chain clear pulse, latches lap/split values, and selects live or lapped digits for the display driver. Sits between the debounced button inputs and the cascade of decade counters.

---
 rtl/stopwatch_ctrl_if.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller signal bundle.
//
// Groups everything between the stopwatch control FSM and its surroundings
// (debounced buttons, the decade-counter chain and the display driver).
//   master : the surroundings. It drives the buttons, the live digits and the
//            saturation flag, and it receives the tick, clear, display and status.
//   slave  : stopwatch_ctrl.
//
// Signal protocol: there is no valid/ready handshake on this bundle. The buttons
// are clk-synchronous levels, and the controller acts only on their rising edges.
// tick_en and cnt_reset are single-cycle strobes that the counter chain must
// consume in the cycle they are high. All other outputs are plain levels.
interface stopwatch_ctrl_if #(
  parameter int NDIG = 4
);
  logic              start_stop;   // run/pause button level
  logic              lap;          // split button level
  logic              clr;          // clear button level
  logic [4*NDIG-1:0] digits_in;    // live BCD value, digit 0 in [3:0]
  logic              max_in;       // chain holds all nines
  logic              tick_en;      // one-cycle count enable to digit 0
  logic              cnt_reset;    // one-cycle clear to the whole chain
  logic [4*NDIG-1:0] disp_digits;  // live or latched lap value
  logic [1:0]        state;        // IDLE=00 RUN=01 PAUSE=10 LAP=11
  logic              lap_active;   // display shows the latched lap value
  logic              overflow;     // sticky saturation flag

  modport master (
    output start_stop, lap, clr, digits_in, max_in,
    input  tick_en, cnt_reset, disp_digits, state, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap, clr, digits_in, max_in,
    output tick_en, cnt_reset, disp_digits, state, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM.
//
// This block decodes the start/stop, lap and clear buttons. It produces the
// prescaled count tick for the least-significant decade counter, the one-cycle
// clear pulse for the counter chain, and the lap (split) latch and display mux.
//
// Ports:
//   clk   : system clock, rising edge.
//   reset : asynchronous, active-high reset.
//   sw    : stopwatch_ctrl_if.slave. This is the button inputs, the live
//           digits, max_in, tick_en, cnt_reset, disp_digits, state,
//           lap_active and overflow.
//
// Parameters:
//   TICK_DIV : clk cycles per count tick (must be >= 2).
//   NDIG     : number of BCD digits in the chain. It must match the interface.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int NDIG     = 4
) (
  input logic            clk,
  input logic            reset,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              cnt_reset_q, cnt_reset_d;
  logic [4*NDIG-1:0] lap_reg_q, lap_reg_d;
  logic              ovf_q, ovf_d;
  logic              start_hist_q, lap_hist_q, clr_hist_q;
  // This flag is low for the first cycle after reset. A button that is already
  // held when reset releases is therefore seen as "old" and not as a new press.
  logic              armed_q;

  logic rise_start, rise_lap, rise_clr;
  logic ev_start, ev_lap, ev_clr;
  logic counting, at_term;

  assign rise_start = armed_q & sw.start_stop & ~start_hist_q;
  assign rise_lap   = armed_q & sw.lap        & ~lap_hist_q;
  assign rise_clr   = armed_q & sw.clr        & ~clr_hist_q;

  // Strict priority clr > start > lap. The winning rise masks the lower rises
  // even when the winner itself is ignored in the current state.
  assign ev_clr   = rise_clr;
  assign ev_start = rise_start & ~rise_clr;
  assign ev_lap   = rise_lap & ~rise_start & ~rise_clr;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign at_term  = counting && (presc_q == TERM);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    cnt_reset_d = 1'b0;
    lap_reg_d   = lap_reg_q;
    ovf_d       = ovf_q;

    if (counting) begin
      presc_d = at_term ? '0 : presc_q + PW'(1);
      tick_d  = at_term & ~sw.max_in;
    end

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (ev_clr) begin
          cnt_reset_d = 1'b1;
          lap_reg_d   = '0;
        end else if (ev_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ev_start) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d   = LAP;
          lap_reg_d = sw.digits_in;
        end
      end
      LAP: begin
        if (ev_clr) begin
          state_d = RUN;
        end else if (ev_start) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          lap_reg_d = sw.digits_in;
        end
      end
      PAUSE: begin
        if (ev_clr) begin
          state_d     = IDLE;
          cnt_reset_d = 1'b1;
          presc_d     = '0;
          ovf_d       = 1'b0;
          lap_reg_d   = '0;
        end else if (ev_start && !ovf_q) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // A saturated chain freezes the stopwatch. This overrides any button
    // transition taken in the same cycle.
    if (at_term && sw.max_in) begin
      state_d = PAUSE;
      ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      cnt_reset_q  <= 1'b0;
      lap_reg_q    <= '0;
      ovf_q        <= 1'b0;
      start_hist_q <= 1'b0;
      lap_hist_q   <= 1'b0;
      clr_hist_q   <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      cnt_reset_q  <= cnt_reset_d;
      lap_reg_q    <= lap_reg_d;
      ovf_q        <= ovf_d;
      start_hist_q <= sw.start_stop;
      lap_hist_q   <= sw.lap;
      clr_hist_q   <= sw.clr;
      armed_q      <= 1'b1;
    end
  end

  assign sw.tick_en     = tick_q;
  assign sw.cnt_reset   = cnt_reset_q;
  assign sw.state       = state_q;
  assign sw.lap_active  = (state_q == LAP);
  assign sw.overflow    = ovf_q;
  assign sw.disp_digits = (state_q == LAP) ? lap_reg_q : sw.digits_in;

endmodule
